// File: rtl/sar_search_ctrl_if.sv
// sar_search_ctrl_if
//   Groups the handshake and comparator signals of the SAR search controller.
//   Parameter WIDTH : search operand width in bits.
//   start        : new search request (sampled only while idle)
//   gt/lt/eq     : external comparator result of target vs. probe
//   probe        : registered trial value for the comparator
//   busy/done    : search in progress / one-cycle completion pulse
//   result       : located value, held until the next done
//   found/err    : match seen / illegal comparator flags seen
//   steps        : number of probes used by the last search
//   Modports: master = requester + comparator side, slave = controller.
interface sar_search_ctrl_if #(
  parameter int unsigned WIDTH = 3
);
  logic             start;
  logic             gt;
  logic             lt;
  logic             eq;
  logic [WIDTH-1:0] probe;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             found;
  logic             err;
  logic [WIDTH:0]   steps;

  modport master (
    output start, gt, lt, eq,
    input  probe, busy, done, result, found, err, steps
  );

  modport slave (
    input  start, gt, lt, eq,
    output probe, busy, done, result, found, err, steps
  );
endinterface

// File: rtl/sar_search_ctrl.sv
// sar_search_ctrl
//   Successive-approximation (binary search) controller driving an external
//   comparator. A search narrows [lo, hi] around the target until the
//   comparator reports eq or the range is exhausted.
//   Ports:
//     clk   : clock, rising edge
//     rst_n : asynchronous active-low reset
//     bus   : sar_search_ctrl_if.slave (start, gt/lt/eq in; probe, busy,
//             done, result, found, err, steps out)
//   Build option:
//     SAR_SEARCH_FLAG_CHECK_EN : when defined, non-one-hot gt/lt/eq ends the
//       search with err=1. When undefined, flags resolve eq > gt > lt
//       (all-zero treated as lt) and err stays 0.
module sar_search_ctrl #(
  parameter int unsigned WIDTH = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  sar_search_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

  localparam logic [WIDTH-1:0] ONE      = 1;
  localparam logic [WIDTH:0]   STEP_ONE = 1;

  state_t           state, state_n;
  logic [WIDTH-1:0] lo, lo_n, hi, hi_n;
  logic [WIDTH-1:0] probe, probe_n, result, result_n;
  logic             found, found_n, err, err_n;
  logic [WIDTH:0]   steps, steps_n;
  logic             illegal, hit, go_up;

  // Midpoint with one extra bit so lo+hi cannot wrap.
  function automatic logic [WIDTH-1:0] mid(input logic [WIDTH-1:0] a,
                                           input logic [WIDTH-1:0] b);
    logic [WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    return WIDTH'(s >> 1);
  endfunction

`ifdef SAR_SEARCH_FLAG_CHECK_EN
  assign illegal = !$onehot({bus.gt, bus.lt, bus.eq});
`else
  assign illegal = 1'b0;
`endif
  // Priority eq > gt > lt; anything that is neither eq nor gt moves down.
  assign hit   = bus.eq;
  assign go_up = bus.gt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      lo     <= '0;
      hi     <= '1;
      probe  <= '0;
      result <= '0;
      found  <= 1'b0;
      err    <= 1'b0;
      steps  <= '0;
    end else begin
      state  <= state_n;
      lo     <= lo_n;
      hi     <= hi_n;
      probe  <= probe_n;
      result <= result_n;
      found  <= found_n;
      err    <= err_n;
      steps  <= steps_n;
    end
  end

  always_comb begin
    state_n  = state;
    lo_n     = lo;
    hi_n     = hi;
    probe_n  = probe;
    result_n = result;
    found_n  = found;
    err_n    = err;
    steps_n  = steps;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_n = SEARCH;
          lo_n    = '0;
          hi_n    = '1;
          probe_n = mid('0, '1);
          steps_n = '0;
        end
      end
      SEARCH: begin
        steps_n = steps + STEP_ONE;
        if (illegal) begin
          state_n  = DONE;
          result_n = probe;
          found_n  = 1'b0;
          err_n    = 1'b1;
        end else if (hit) begin
          state_n  = DONE;
          result_n = probe;
          found_n  = 1'b1;
          err_n    = 1'b0;
        end else if (go_up) begin
          if (probe < hi) begin
            lo_n    = probe + ONE;
            probe_n = mid(probe + ONE, hi);
          end else begin
            state_n  = DONE;
            result_n = probe;
            found_n  = 1'b0;
            err_n    = 1'b0;
          end
        end else begin
          if (probe > lo) begin
            hi_n    = probe - ONE;
            probe_n = mid(lo, probe - ONE);
          end else begin
            state_n  = DONE;
            result_n = probe;
            found_n  = 1'b0;
            err_n    = 1'b0;
          end
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign bus.probe  = probe;
  assign bus.busy   = (state == SEARCH);
  assign bus.done   = (state == DONE);
  assign bus.result = result;
  assign bus.found  = found;
  assign bus.err    = err;
  assign bus.steps  = steps;

endmodule

// File: tb/tb_sar_search_ctrl.sv
// tb_sar_search_ctrl
//   Directed bench for sar_search_ctrl (WIDTH=3). The bench plays the
//   comparator: at each falling edge it reads probe and drives gt/lt/eq
//   for a chosen target (or forced flag patterns).
module tb_sar_search_ctrl;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  sar_search_ctrl_if #(.WIDTH(3)) bus ();

  sar_search_ctrl #(.WIDTH(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int seen[$];
  int busy_cycles;
  int done_pulses;
  int done_gap;
  int cap_result;
  int cap_found;
  int cap_err;
  int cap_steps;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // mode 0: true compare; mode 1: gt forced; mode 2: gt=lt=1 on first probe, then compare
  task automatic drive_flags(input int target, input int mode, input bit first);
    int p;
    p = int'(bus.probe);
    if (mode == 1 || (mode == 2 && first)) begin
      bus.gt = 1'b1;
      bus.lt = (mode == 2);
      bus.eq = 1'b0;
    end else begin
      bus.gt = (target > p);
      bus.lt = (target < p);
      bus.eq = (target == p);
    end
  endtask

  task automatic run_search(input int target, input int mode);
    bit first;
    int last_busy;
    seen.delete();
    busy_cycles = 0;
    done_pulses = 0;
    done_gap    = -1;
    first       = 1'b1;
    last_busy   = -1;
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (bus.busy) begin
        seen.push_back(int'(bus.probe));
        busy_cycles++;
        drive_flags(target, mode, first);
        first = 1'b0;
        last_busy = c;
      end else if (bus.done) begin
        done_pulses++;
        done_gap   = c - last_busy;
        cap_result = int'(bus.result);
        cap_found  = int'(bus.found);
        cap_err    = int'(bus.err);
        cap_steps  = int'(bus.steps);
        bus.gt = 1'b0;
        bus.lt = 1'b0;
        bus.eq = 1'b0;
      end else if (done_pulses > 0) begin
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    bus.start = 1'b0;
    bus.gt    = 1'b0;
    bus.lt    = 1'b0;
    bus.eq    = 1'b0;
    rst_n     = 1'b0;
    repeat (2) @(negedge clk);

    chk("rst_probe",  bus.probe,  0);
    chk("rst_busy",   bus.busy,   0);
    chk("rst_done",   bus.done,   0);
    chk("rst_result", bus.result, 0);
    chk("rst_found",  bus.found,  0);
    chk("rst_err",    bus.err,    0);
    chk("rst_steps",  bus.steps,  0);
    rst_n = 1'b1;
    @(negedge clk);

    // Target 3: hit on the first probe
    run_search(3, 0);
    chk("t3_nprobe", seen.size(), 1);
    chk("t3_p0",     seen[0], 3);
    chk("t3_pulses", done_pulses, 1);
    chk("t3_gap",    done_gap, 1);
    chk("t3_result", cap_result, 3);
    chk("t3_found",  cap_found, 1);
    chk("t3_steps",  cap_steps, 1);

    // Target 7: climbs to the top of the range
    run_search(7, 0);
    chk("t7_nprobe", seen.size(), 4);
    chk("t7_p0",     seen[0], 3);
    chk("t7_p1",     seen[1], 5);
    chk("t7_p2",     seen[2], 6);
    chk("t7_p3",     seen[3], 7);
    chk("t7_busy",   busy_cycles, 4);
    chk("t7_pulses", done_pulses, 1);
    chk("t7_gap",    done_gap, 1);
    chk("t7_result", cap_result, 7);
    chk("t7_found",  cap_found, 1);
    chk("t7_steps",  cap_steps, 4);
    chk("t7_hold_result", bus.result, 7);
    chk("t7_hold_steps",  bus.steps, 4);
    chk("t7_hold_done",   bus.done, 0);
    chk("t7_hold_probe",  bus.probe, 7);

    // Target 0: descends to the bottom
    run_search(0, 0);
    chk("t0_nprobe", seen.size(), 3);
    chk("t0_p0",     seen[0], 3);
    chk("t0_p1",     seen[1], 1);
    chk("t0_p2",     seen[2], 0);
    chk("t0_result", cap_result, 0);
    chk("t0_found",  cap_found, 1);
    chk("t0_steps",  cap_steps, 3);

    // gt forced every cycle: exhaustion at the top
    run_search(0, 1);
    chk("gx_nprobe", seen.size(), 4);
    chk("gx_p3",     seen[3], 7);
    chk("gx_pulses", done_pulses, 1);
    chk("gx_result", cap_result, 7);
    chk("gx_found",  cap_found, 0);
    chk("gx_steps",  cap_steps, 4);
    chk("gx_err",    cap_err, 0);

    // gt=lt=1 on the first probe, target 5 afterwards
    run_search(5, 2);
`ifdef SAR_SEARCH_FLAG_CHECK_EN
    chk("il_nprobe", seen.size(), 1);
    chk("il_err",    cap_err, 1);
    chk("il_found",  cap_found, 0);
    chk("il_result", cap_result, 3);
    chk("il_steps",  cap_steps, 1);
`else
    chk("il_nprobe", seen.size(), 2);
    chk("il_p1",     seen[1], 5);
    chk("il_err",    cap_err, 0);
    chk("il_found",  cap_found, 1);
    chk("il_result", cap_result, 5);
    chk("il_steps",  cap_steps, 2);
`endif

    // Reset during the second SEARCH cycle
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    chk("mr_busy1", bus.busy, 1);
    drive_flags(7, 0, 1'b0);
    @(negedge clk);
    chk("mr_busy2",  bus.busy, 1);
    chk("mr_probe2", bus.probe, 5);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_probe",  bus.probe,  0);
    chk("mr_busy",   bus.busy,   0);
    chk("mr_done",   bus.done,   0);
    chk("mr_result", bus.result, 0);
    chk("mr_found",  bus.found,  0);
    chk("mr_err",    bus.err,    0);
    chk("mr_steps",  bus.steps,  0);
    bus.gt = 1'b0;
    bus.lt = 1'b0;
    bus.eq = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    chk("mr_idle_busy", bus.busy, 0);
    chk("mr_idle_done", bus.done, 0);
    run_search(3, 0);
    chk("mr_nprobe", seen.size(), 1);
    chk("mr_p0",     seen[0], 3);
    chk("mr_pulses", done_pulses, 1);
    chk("mr_result", cap_result, 3);
    chk("mr_steps2", cap_steps, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
